vreg_wr_arbiter: RTL and testbench
==================================

// Module: vreg_wr_arbiter
// PURPOSE
//  Shares the two write ports (A, B) of the vector register file among N_REQ producers (ALU lanes, load unit, etc.).
//  Each cycle it grants up to two valid requests in round-robin order and blocks same-address collisions.
//  Granted writes are registered and driven onto we_a/w_addr_a/data_in_a and we_b/w_addr_b/data_in_b.
//  Also publishes a per-register bitmap of writes in flight, used for read-hazard stalls.
// PARAMETERS
//  ADDR_W  4    register address width (2**ADDR_W registers)
//  DATA_W  128  vector data width
//  N_REQ   4    number of requesters (2..8)
// PORTS
//  clk         in   1               clock, all state on rising edge
//  rst         in   1               asynchronous reset, active-high
//  req_valid   in   N_REQ           requester i has a write pending
//  req_addr    in   N_REQ*ADDR_W    requester i dest register, slice [i*ADDR_W +: ADDR_W]
//  req_data    in   N_REQ*DATA_W    requester i write data, slice [i*DATA_W +: DATA_W]
//  req_ready   out  N_REQ           requester i granted this cycle (combinational)
//  we_a        out  1               write enable, port A (registered)
//  w_addr_a    out  ADDR_W          write address, port A (registered)
//  data_in_a   out  DATA_W          write data, port A (registered)
//  we_b        out  1               write enable, port B (registered)
//  w_addr_b    out  ADDR_W          write address, port B (registered)
//  data_in_b   out  DATA_W          write data, port B (registered)
//  wr_pending  out  2**ADDR_W       bit r=1 when register r is being written on current output cycle
// BEHAVIOUR
//  Reset: rr_ptr=0; we_a=we_b=0; w_addr_*=0; data_in_*=0; wr_pending=0. Asynchronous: any in-flight write is dropped.
//  Handshake: a transfer occurs when req_valid[i] && req_ready[i]. req_valid must not depend on req_ready.
//   Once asserted, a requester holds valid, addr and data stable until it is granted.
//  Grant selection (combinational, same cycle):
//   scan i = rr_ptr, rr_ptr+1, ... modulo N_REQ
//   the first valid requester is assigned to port A
//   the next valid requester whose addr != port A addr is assigned to port B
//   valid requesters with addr == port A addr are skipped (stall) this cycle
//   at most 2 grants per cycle; req_ready=1 only for the granted requesters
//  Output register (1-cycle latency):
//   at the edge after a grant, we_x=1 and w_addr_x/data_in_x = the granted request
//   an unused port has we_x=0; its addr/data hold their previous values
//  wr_pending: decode of the registered (we_a,w_addr_a) OR (we_b,w_addr_b); never two bits from one port.
//   Port A and port B addresses are never equal while both we are high.
//  Round-robin pointer:
//   after a cycle with grants, rr_ptr = (index of last granted requester + 1) mod N_REQ
//   with no grants, rr_ptr is unchanged
//   gives starvation freedom: every valid requester is granted within N_REQ cycles
//  Boundaries:
//   single valid request: goes to port A only, we_b=0
//   all requests share one addr: exactly one grant per cycle, in rotation
//   rr_ptr wraps N_REQ-1 -> 0
// TESTING
//  1 Single write: rr_ptr=0, req0 addr=3 data=0xAA..AA.
//    -> req_ready=0001 same cycle; next cycle we_a=1, w_addr_a=3, data_in_a=0xAA..AA, we_b=0, wr_pending=0x0008.
//  2 Full load: all four valid, addrs 1,2,3,4, rr_ptr=0.
//    -> cycle1 grants 0(A),1(B), rr_ptr=2; cycle2 grants 2(A),3(B), rr_ptr=0; wr_pending=0x0006 then 0x0018.
//  3 Collision: req0 addr5, req1 addr5, req2 addr6, rr_ptr=0.
//    -> ready=0101 (A=5, B=6); req1 stalls; next cycle req1 is granted on A.
//  4 Wrap: rr_ptr=3, req3 addr7, req0 addr8.
//    -> A=req3, B=req0, rr_ptr=1.
//  5 Idle: no valid for 3 cycles.
//    -> we_a=we_b=0, wr_pending=0, rr_ptr unchanged.
//  6 Reset mid-op: assert rst while we_a=1 and we_b=1.
//    -> we_a, we_b and wr_pending drop without a clock edge; after release the first grant starts from req0.

Source files
------------

// File: rtl/vreg_wr_arbiter.sv
// Write-port arbiter for the vector register file: grants up to two requesters per
// cycle in round-robin order onto ports A/B, never two writes to the same register.
module vreg_wr_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 128,
    parameter int N_REQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      we_a,
    output logic [ADDR_W-1:0]         w_addr_a,
    output logic [DATA_W-1:0]         data_in_a,
    output logic                      we_b,
    output logic [ADDR_W-1:0]         w_addr_b,
    output logic [DATA_W-1:0]         data_in_b,
    output logic [(2**ADDR_W)-1:0]    wr_pending
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IW    = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  sel_a;
    logic [PTR_W-1:0]  sel_b;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W-1:0]  last;
    logic [PTR_W-1:0]  rr_next;
    logic [IW-1:0]     idx_w;
    logic [IW-1:0]     last_w;
    logic              found_a;
    logic              found_b;
    logic [ADDR_W-1:0] addr_a_sel;

    // Walk requesters starting at rr_ptr; B takes the next valid one whose
    // destination differs from A, so same-register requesters simply wait.
    always_comb begin
        req_ready  = '0;
        found_a    = 1'b0;
        found_b    = 1'b0;
        sel_a      = '0;
        sel_b      = '0;
        idx        = '0;
        idx_w      = '0;
        addr_a_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_w = {1'b0, rr_ptr} + IW'(k);
            if (idx_w >= IW'(N_REQ)) begin
                idx_w = idx_w - IW'(N_REQ);
            end
            idx = idx_w[PTR_W-1:0];
            if (req_valid[idx]) begin
                if (!found_a) begin
                    found_a        = 1'b1;
                    sel_a          = idx;
                    addr_a_sel     = addr_arr[idx];
                    req_ready[idx] = 1'b1;
                end else if (!found_b && (addr_arr[idx] != addr_a_sel)) begin
                    found_b        = 1'b1;
                    sel_b          = idx;
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        last    = found_b ? sel_b : sel_a;
        last_w  = {1'b0, last} + IW'(1);
        rr_next = (last_w >= IW'(N_REQ)) ? '0 : last_w[PTR_W-1:0];
    end

    // An unused port drops its enable but keeps its last address/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            we_a      <= 1'b0;
            w_addr_a  <= '0;
            data_in_a <= '0;
            we_b      <= 1'b0;
            w_addr_b  <= '0;
            data_in_b <= '0;
        end else begin
            we_a <= found_a;
            we_b <= found_b;
            if (found_a) begin
                w_addr_a  <= addr_arr[sel_a];
                data_in_a <= data_arr[sel_a];
                rr_ptr    <= rr_next;
            end
            if (found_b) begin
                w_addr_b  <= addr_arr[sel_b];
                data_in_b <= data_arr[sel_b];
            end
        end
    end

    always_comb begin
        wr_pending = '0;
        for (int r = 0; r < NREG; r++) begin
            wr_pending[r] = (we_a && (w_addr_a == ADDR_W'(r))) ||
                            (we_b && (w_addr_b == ADDR_W'(r)));
        end
    end

endmodule

// File: tb/tb_vreg_wr_arbiter.sv
// Directed bench for vreg_wr_arbiter: same-cycle grants checked at drive time,
// registered port outputs checked one edge later against a queue of expected writes.
module tb_vreg_wr_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 128;
    localparam int N_REQ  = 4;

    localparam logic [DATA_W-1:0] D0 = {16{8'hAA}};
    localparam logic [DATA_W-1:0] D1 = {16{8'hB1}};
    localparam logic [DATA_W-1:0] D2 = {16{8'hC2}};
    localparam logic [DATA_W-1:0] D3 = {16{8'hD3}};

    typedef struct packed {
        logic              we_a;
        logic [ADDR_W-1:0] addr_a;
        logic [DATA_W-1:0] data_a;
        logic              we_b;
        logic [ADDR_W-1:0] addr_b;
        logic [DATA_W-1:0] data_b;
        logic [15:0]       pend;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    we_a;
    logic [ADDR_W-1:0]       w_addr_a;
    logic [DATA_W-1:0]       data_in_a;
    logic                    we_b;
    logic [ADDR_W-1:0]       w_addr_b;
    logic [DATA_W-1:0]       data_in_b;
    logic [15:0]             wr_pending;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    vreg_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REQ(N_REQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .we_a       (we_a),
        .w_addr_a   (w_addr_a),
        .data_in_a  (data_in_a),
        .we_b       (we_b),
        .w_addr_b   (w_addr_b),
        .data_in_b  (data_in_b),
        .wr_pending (wr_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic wa, input logic [ADDR_W-1:0] aa,
                                input logic [DATA_W-1:0] da, input logic wb,
                                input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db,
                                input logic [15:0] pend);
        exp_t e;
        e.we_a   = wa;
        e.addr_a = aa;
        e.data_a = da;
        e.we_b   = wb;
        e.addr_b = ab;
        e.data_b = db;
        e.pend   = pend;
        return e;
    endfunction

    // Drive one cycle of requests away from the edge, check the grant vector, queue the write
    task automatic applyStimulus(input string tag, input logic [N_REQ-1:0] valid,
                                 input logic [N_REQ*ADDR_W-1:0] addrs,
                                 input logic [N_REQ-1:0] exp_ready, input exp_t e);
        @(negedge clk);
        req_valid = valid;
        req_addr  = addrs;
        #1;
        checkValue({tag, ".ready"}, DATA_W'(req_ready), DATA_W'(exp_ready));
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s.queue: got empty scoreboard, expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            checkValue({tag, ".we_a"},   DATA_W'(we_a),       DATA_W'(e.we_a));
            checkValue({tag, ".addr_a"}, DATA_W'(w_addr_a),   DATA_W'(e.addr_a));
            checkValue({tag, ".data_a"}, data_in_a,           e.data_a);
            checkValue({tag, ".we_b"},   DATA_W'(we_b),       DATA_W'(e.we_b));
            checkValue({tag, ".addr_b"}, DATA_W'(w_addr_b),   DATA_W'(e.addr_b));
            checkValue({tag, ".data_b"}, data_in_b,           e.data_b);
            checkValue({tag, ".pend"},   DATA_W'(wr_pending), DATA_W'(e.pend));
        end
    endtask

    task automatic step(input string tag, input logic [N_REQ-1:0] valid,
                        input logic [N_REQ*ADDR_W-1:0] addrs,
                        input logic [N_REQ-1:0] exp_ready, input exp_t e);
        applyStimulus(tag, valid, addrs, exp_ready, e);
        checkOutput(tag);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = {D3, D2, D1, D0};
        #12;
        checkValue("reset.we_a",   DATA_W'(we_a),       '0);
        checkValue("reset.we_b",   DATA_W'(we_b),       '0);
        checkValue("reset.addr_a", DATA_W'(w_addr_a),   '0);
        checkValue("reset.data_b", data_in_b,           '0);
        checkValue("reset.pend",   DATA_W'(wr_pending), '0);
        @(negedge clk);
        rst = 1'b0;

        // Full load from rr_ptr=0: two pairs, pointer returns to 0
        step("full1", 4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b0011,
             mk(1'b1, 4'd1, D0, 1'b1, 4'd2, D1, 16'h0006));
        step("full2", 4'b1100, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b1100,
             mk(1'b1, 4'd3, D2, 1'b1, 4'd4, D3, 16'h0018));
        // Single write goes to A only
        step("single", 4'b0001, {4'd0, 4'd0, 4'd0, 4'd3}, 4'b0001,
             mk(1'b1, 4'd3, D0, 1'b0, 4'd4, D3, 16'h0008));
        step("fill3", 4'b1000, {4'd9, 4'd0, 4'd0, 4'd0}, 4'b1000,
             mk(1'b1, 4'd9, D3, 1'b0, 4'd4, D3, 16'h0200));
        // Collision: req1 shares A's address and must wait one cycle
        step("coll1", 4'b0111, {4'd0, 4'd6, 4'd5, 4'd5}, 4'b0101,
             mk(1'b1, 4'd5, D0, 1'b1, 4'd6, D2, 16'h0060));
        step("coll2", 4'b0010, {4'd0, 4'd6, 4'd5, 4'd5}, 4'b0010,
             mk(1'b1, 4'd5, D1, 1'b0, 4'd6, D2, 16'h0020));
        step("fill2", 4'b0100, {4'd0, 4'd10, 4'd0, 4'd0}, 4'b0100,
             mk(1'b1, 4'd10, D2, 1'b0, 4'd6, D2, 16'h0400));
        // Wrap: rr_ptr=3, A=req3, B=req0
        step("wrap", 4'b1001, {4'd7, 4'd0, 4'd0, 4'd8}, 4'b1001,
             mk(1'b1, 4'd7, D3, 1'b1, 4'd8, D0, 16'h0180));
        for (int i = 0; i < 3; i++) begin
            step("idle", 4'b0000, '0, 4'b0000,
                 mk(1'b0, 4'd7, D3, 1'b0, 4'd8, D0, 16'h0000));
        end
        // Pointer held at 1 across idle; same-address rotation afterwards
        step("same1", 4'b1111, {4'd11, 4'd11, 4'd11, 4'd11}, 4'b0010,
             mk(1'b1, 4'd11, D1, 1'b0, 4'd8, D0, 16'h0800));
        step("same2", 4'b1101, {4'd11, 4'd11, 4'd11, 4'd11}, 4'b0100,
             mk(1'b1, 4'd11, D2, 1'b0, 4'd8, D0, 16'h0800));
        step("same3", 4'b1001, {4'd11, 4'd11, 4'd11, 4'd11}, 4'b1000,
             mk(1'b1, 4'd11, D3, 1'b0, 4'd8, D0, 16'h0800));
        step("same4", 4'b0001, {4'd11, 4'd11, 4'd11, 4'd11}, 4'b0001,
             mk(1'b1, 4'd11, D0, 1'b0, 4'd8, D0, 16'h0800));

        // Reset while both ports write: outputs drop with no clock edge
        applyStimulus("pre_rst", 4'b0011, {4'd0, 4'd0, 4'd13, 4'd12}, 4'b0011,
                      mk(1'b1, 4'd13, D1, 1'b1, 4'd12, D0, 16'h3000));
        checkOutput("pre_rst");
        req_valid = '0;
        #1;
        rst = 1'b1;
        #1;
        checkValue("midrst.we_a",   DATA_W'(we_a),       '0);
        checkValue("midrst.we_b",   DATA_W'(we_b),       '0);
        checkValue("midrst.pend",   DATA_W'(wr_pending), '0);
        checkValue("midrst.addr_a", DATA_W'(w_addr_a),   '0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 4'b1001, {4'd15, 4'd0, 4'd0, 4'd14}, 4'b1001,
             mk(1'b1, 4'd14, D0, 1'b1, 4'd15, D3, 16'hC000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
